param_seq_detector: RTL and testbench

Parametrised Mealy serial-pattern detector, the successor to the fixed 4-bit "1100"/"0011" detector. It compares a 1-bit serial stream against NUM_PAT runtime-programmable patterns of programmable length (2..PAT_W) in one of two modes: framed (non-overlapping) or sliding (overlapping). It has per-pattern match flags, a combined Mealy dec, a frame strobe and a saturating match counter. It sits between the serial input front-end and the control FSMs that consume dec.

---
 rtl/seq_det_pkg.sv | 42 ++++
 rtl/seq_det_cmp.sv | 31 +++
 rtl/param_seq_detector.sv | 158 +++++++++++++++
 tb/tb_param_seq_detector.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared types and constants for the parametrised serial-pattern detector.
//   mode_e       : detection mode (framed / sliding)
//   DEF_LEN      : pattern length loaded at reset (legacy 4-bit detector)
//   DEF_PAT0/1   : legacy patterns 1100 and 0011
//   LEN_W        : width of the length field used by clamp_len()
//   def_pattern(): reset value of pattern slot idx
//   clamp_len()  : folds an illegal programmed length into 2..max_len
// ---------------------------------------------------------------------------
package seq_det_pkg;

   typedef enum logic {
      MODE_FRAMED  = 1'b0,
      MODE_SLIDING = 1'b1
   } mode_e;

   localparam int         DEF_LEN  = 4;
   localparam int         LEN_W    = 8;
   localparam logic [3:0] DEF_PAT0 = 4'b1100;
   localparam logic [3:0] DEF_PAT1 = 4'b0011;

   function automatic logic [3:0] def_pattern(input int idx);
      logic [3:0] p;
      case (idx)
         0:       p = DEF_PAT0;
         1:       p = DEF_PAT1;
         default: p = 4'b0000;
      endcase
      return p;
   endfunction

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] raw,
                                                  input int max_len);
      logic [LEN_W-1:0] r;
      if (int'(raw) < 2)            r = LEN_W'(2);
      else if (int'(raw) > max_len) r = LEN_W'(max_len);
      else                          r = raw;
      return r;
   endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// ---------------------------------------------------------------------------
// seq_det_cmp
// Combinational length-masked comparator: eq_o is high when the low len_i
// bits of cand_i equal the low len_i bits of pat_i. Bits at or above len_i
// are ignored on both sides.
//   cand_i : candidate window, newest bit in LSB
//   pat_i  : programmed pattern, right-aligned
//   len_i  : active pattern length
//   eq_o   : masked equality
// ---------------------------------------------------------------------------
module seq_det_cmp #(
   parameter int PAT_W = 8,
   parameter int LW    = 4
) (
   input  logic [PAT_W-1:0] cand_i,
   input  logic [PAT_W-1:0] pat_i,
   input  logic [LW-1:0]    len_i,
   output logic             eq_o
);

   logic [PAT_W-1:0] mask;

   always_comb begin
      mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (i < int'(len_i));
      end
      eq_o = (((cand_i ^ pat_i) & mask) == '0);
   end

endmodule

// File: rtl/param_seq_detector.sv
// ---------------------------------------------------------------------------
// param_seq_detector
// Mealy serial-pattern detector with NUM_PAT runtime-programmable patterns of
// length 2..PAT_W, framed (non-overlapping) or sliding (overlapping) mode.
//   clk, rst    : clock, asynchronous active-high reset
//   in/in_valid : serial bit and its qualifier
//   cfg_we      : load cfg_pat/cfg_len/cfg_mode and restart detection
//   cnt_clr     : synchronous clear of match_cnt
//   match       : per-pattern hit on the current bit (combinational)
//   dec         : OR of match
//   frame_done  : current bit closes a frame (framed mode only)
//   match_cnt   : saturating count of cycles with dec=1
// ---------------------------------------------------------------------------
module param_seq_detector
   import seq_det_pkg::*;
#(
   parameter int PAT_W   = 8,
   parameter int NUM_PAT = 2,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in,
   input  logic                       in_valid,
   input  logic                       cfg_we,
   input  logic [NUM_PAT*PAT_W-1:0]   cfg_pat,
   input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
   input  logic                       cfg_mode,
   input  logic                       cnt_clr,
   output logic                       dec,
   output logic [NUM_PAT-1:0]         match,
   output logic                       frame_done,
   output logic [CNT_W-1:0]           match_cnt
);

   localparam int LW = $clog2(PAT_W+1);

   function automatic logic [NUM_PAT*PAT_W-1:0] rst_pats();
      logic [NUM_PAT*PAT_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_PAT; i++) begin
         r[i*PAT_W +: PAT_W] = PAT_W'(def_pattern(i));
      end
      return r;
   endfunction

   localparam logic [NUM_PAT*PAT_W-1:0] RST_PAT = rst_pats();
   // Default length is clamped so narrow instances (PAT_W < 4) stay legal.
   localparam logic [LW-1:0] RST_LEN = LW'(clamp_len(LEN_W'(DEF_LEN), PAT_W));

   logic [PAT_W-2:0]         hist_q, hist_d;
   logic [LW-1:0]            fill_q, fill_d;
   logic [LW-1:0]            bit_idx_q, bit_idx_d;
   logic [LW-1:0]            len_q, len_d;
   mode_e                    mode_q, mode_d;
   logic [NUM_PAT*PAT_W-1:0] pat_q, pat_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;

   logic [PAT_W-1:0]   cand;
   logic [NUM_PAT-1:0] hit;
   logic [LW-1:0]      len_m1;
   logic               last_bit;
   logic               fill_ok;
   logic               qualify;
   logic               data_ok;

   // Window of the newest PAT_W bits including the current one; the
   // comparator masks off everything older than the active length.
   assign cand = {hist_q, in};

   for (genvar g = 0; g < NUM_PAT; g++) begin : g_cmp
      seq_det_cmp #(
         .PAT_W (PAT_W),
         .LW    (LW)
      ) u_cmp (
         .cand_i (cand),
         .pat_i  (pat_q[g*PAT_W +: PAT_W]),
         .len_i  (len_q),
         .eq_o   (hit[g])
      );
   end

   // Mealy outputs. A bit arriving together with cfg_we is dropped, and the
   // outputs are held low while reset is asserted.
   always_comb begin
      len_m1     = len_q - LW'(1);
      last_bit   = (bit_idx_q == len_m1);
      fill_ok    = (fill_q >= len_m1);
      data_ok    = in_valid & ~cfg_we & ~rst;
      qualify    = 1'b0;
      frame_done = 1'b0;
      if (mode_q == MODE_FRAMED) begin
         qualify    = last_bit & fill_ok;
         frame_done = data_ok & last_bit;
      end else begin
         qualify    = fill_ok;
      end
      match = (data_ok & qualify) ? hit : '0;
      dec   = |match;
   end

   // Next-state logic.
   always_comb begin
      hist_d    = hist_q;
      fill_d    = fill_q;
      bit_idx_d = bit_idx_q;
      len_d     = len_q;
      mode_d    = mode_q;
      pat_d     = pat_q;
      cnt_d     = cnt_q;

      if (cnt_clr) begin
         cnt_d = '0;
      end else if (dec && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (cfg_we) begin
         len_d     = LW'(clamp_len(LEN_W'(cfg_len), PAT_W));
         mode_d    = mode_e'(cfg_mode);
         pat_d     = cfg_pat;
         hist_d    = '0;
         fill_d    = '0;
         bit_idx_d = '0;
      end else if (in_valid) begin
         hist_d = cand[PAT_W-2:0];
         if (fill_q != LW'(PAT_W)) begin
            fill_d = fill_q + LW'(1);
         end
         if (mode_q == MODE_FRAMED) begin
            bit_idx_d = last_bit ? '0 : bit_idx_q + LW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q    <= '0;
         fill_q    <= '0;
         bit_idx_q <= '0;
         len_q     <= RST_LEN;
         mode_q    <= MODE_FRAMED;
         pat_q     <= RST_PAT;
         cnt_q     <= '0;
      end else begin
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         bit_idx_q <= bit_idx_d;
         len_q     <= len_d;
         mode_q    <= mode_d;
         pat_q     <= pat_d;
         cnt_q     <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_param_seq_detector
// Self-checking bench for param_seq_detector. The reference model keeps the
// received bits in a queue and decides hits from bit positions since the last
// configuration load; expected outputs go into exp_q and a negedge monitor
// pops and compares them.
// ---------------------------------------------------------------------------
module tb_param_seq_detector;

   localparam int PAT_W   = 8;
   localparam int NUM_PAT = 2;
   localparam int CNT_W   = 4;
   localparam int LW      = $clog2(PAT_W+1);
   localparam int W       = 1 + NUM_PAT + 1 + CNT_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                     in = 1'b0, in_valid = 1'b0, cfg_we = 1'b0;
   logic                     cfg_mode = 1'b0, cnt_clr = 1'b0;
   logic [NUM_PAT*PAT_W-1:0] cfg_pat = '0;
   logic [LW-1:0]            cfg_len = '0;
   logic                     dec, frame_done;
   logic [NUM_PAT-1:0]       match;
   logic [CNT_W-1:0]         match_cnt;

   param_seq_detector #(
      .PAT_W   (PAT_W),
      .NUM_PAT (NUM_PAT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in         (in),
      .in_valid   (in_valid),
      .cfg_we     (cfg_we),
      .cfg_pat    (cfg_pat),
      .cfg_len    (cfg_len),
      .cfg_mode   (cfg_mode),
      .cnt_clr    (cnt_clr),
      .dec        (dec),
      .match      (match),
      .frame_done (frame_done),
      .match_cnt  (match_cnt)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int n_vec   = 0;
   int n_bad   = 0;
   int fd_seen = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   int               m_len;
   int               m_mode;
   logic [PAT_W-1:0] m_pat [NUM_PAT];
   logic             m_bits[$];
   int               m_nbits;
   int               m_cnt;

   function automatic void model_reset();
      m_len   = 4;
      m_mode  = 0;
      m_pat[0] = PAT_W'(4'b1100);
      m_pat[1] = PAT_W'(4'b0011);
      m_bits.delete();
      m_nbits = 0;
      m_cnt   = 0;
   endfunction

   function automatic logic [W-1:0] model_out(input logic v, input logic b,
                                              input logic we);
      logic [NUM_PAT-1:0] mt;
      logic fd, q, ok, sb;
      int nb;
      mt = '0;
      fd = 1'b0;
      q  = 1'b0;
      nb = m_nbits + 1;
      if (v && !we) begin
         if (m_mode == 0) begin
            q  = ((nb % m_len) == 0);
            fd = q;
         end else begin
            q = (nb >= m_len);
         end
         if (q) begin
            for (int i = 0; i < NUM_PAT; i++) begin
               ok = 1'b1;
               for (int k = 0; k < m_len; k++) begin
                  sb = (k == 0) ? b : m_bits[m_bits.size() - k];
                  if (sb !== m_pat[i][k]) ok = 1'b0;
               end
               mt[i] = ok;
            end
         end
      end
      return {|mt, mt, fd, CNT_W'(m_cnt)};
   endfunction

   function automatic void model_step(input logic v, input logic b, input logic we,
                                      input logic clr, input logic d);
      int raw;
      if (clr) m_cnt = 0;
      else if (d && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (we) begin
         raw    = int'(cfg_len);
         m_len  = (raw < 2) ? 2 : (raw > PAT_W) ? PAT_W : raw;
         m_mode = int'(cfg_mode);
         for (int i = 0; i < NUM_PAT; i++) m_pat[i] = cfg_pat[i*PAT_W +: PAT_W];
         m_bits.delete();
         m_nbits = 0;
      end else if (v) begin
         m_bits.push_back(b);
         if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
         m_nbits++;
      end
   endfunction

   // ---------------- driver tasks ----------------
   // Called at posedge+1; drives one cycle and returns at the next posedge+1.
   task automatic cycle(input logic v, input logic b, input logic we, input logic clr);
      logic [W-1:0] e;
      in_valid = v;
      in       = b;
      cfg_we   = we;
      cnt_clr  = clr;
      e = model_out(v, b, we);
      exp_q.push_back(e);
      @(posedge clk);
      model_step(v, b, we, clr, e[W-1]);
      #1;
   endtask

   task automatic do_cfg(input int len, input logic mode, input logic [PAT_W-1:0] p0,
                         input logic [PAT_W-1:0] p1);
      cfg_len  = LW'(len);
      cfg_mode = mode;
      cfg_pat  = {p1, p0};
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic stream(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i], 1'b0, 1'b0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!rst && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("outputs", 32'({dec, match, frame_done, match_cnt}), 32'(e));
         if (frame_done) fd_seen++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] f;
      logic v, b, we, clr;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in       = 1'b1;
      #1;
      check("reset_outputs", 32'({dec, match, frame_done, match_cnt}), 32'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      // Legacy behaviour: every 4-bit frame, MSB first.
      fd_seen = 0;
      for (int i = 0; i < 16; i++) begin
         f = 4'(i);
         stream(16'(f), 4);
      end
      check("legacy_frame_done", 32'(fd_seen), 32'd16);
      check("legacy_cnt", 32'(match_cnt), 32'd2);

      // Sliding, len 3, overlapping 101 and 000.
      do_cfg(3, 1'b1, 8'b101, 8'b000);
      stream(16'b10101000, 8);

      // Framed vs sliding on a stream where 1100 straddles a frame boundary.
      do_cfg(4, 1'b0, 8'b1100, 8'b0011);
      stream(16'b01100110, 8);
      do_cfg(4, 1'b1, 8'b1100, 8'b0011);
      stream(16'b01100110, 8);

      // Gapped valid, with garbage on in during the gaps.
      do_cfg(4, 1'b0, 8'hfc, 8'h03);
      for (int i = 3; i >= 0; i--) begin
         cycle(1'b0, 1'(i & 1), 1'b0, 1'b0);
         cycle(1'b1, 1'(4'b1100 >> i), 1'b0, 1'b0);
      end

      // Config load coincident with a valid bit mid-frame.
      stream(16'b11, 2);
      cfg_len = LW'(4); cfg_mode = 1'b0; cfg_pat = {8'b0011, 8'b1100};
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      stream(16'b1100, 4);

      // Illegal lengths clamp to 2 and PAT_W.
      do_cfg(0, 1'b1, 8'b10, 8'b01);
      stream(16'b1010, 4);
      do_cfg(15, 1'b0, 8'b10110011, 8'hff);
      stream(16'b1011001110110011, 16);

      // Async reset mid-frame.
      do_cfg(3, 1'b0, 8'b110, 8'b111);
      stream(16'b11, 2);
      in_valid = 1'b1;
      in       = 1'b0;
      #1;
      check("pre_reset_dec", 32'(dec), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("async_reset_outputs", 32'({dec, match, frame_done, match_cnt}), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      stream(16'b1101100, 7);

      // Saturation with a 4-bit counter, then clear against a hit.
      do_cfg(2, 1'b1, 8'b11, 8'b11);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 18; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("cnt_saturated", 32'(match_cnt), 32'd15);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      check("cnt_clr_wins", 32'(match_cnt), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 900; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         b   = 1'($urandom_range(0, 1));
         we  = ($urandom_range(0, 63) == 0);
         clr = ($urandom_range(0, 31) == 0);
         if (we) begin
            cfg_len  = LW'($urandom_range(0, 15));
            cfg_mode = 1'($urandom_range(0, 1));
            cfg_pat  = NUM_PAT*PAT_W'($urandom);
         end
         cycle(v, b, we, clr);
      end

      in_valid = 1'b0;
      cfg_we   = 1'b0;
      cnt_clr  = 1'b0;
      @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
